// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults and FSM state type for the dual-port data memory.
//   DEF_DATA_W / DEF_ADDR_W / DEF_DEPTH : default geometry (16-bit words, 16-bit address, 256 words)
//   state_t                             : init sequencer state (ST_INIT, ST_RUN)
package dmem_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DEPTH  = 256;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_init_seq.sv
// dmem_init_seq: after reset, walks cnt over 0..DEPTH-1 and emits one init write
// per cycle (mem[cnt] = cnt), then raises ready and stays in RUN until the next reset.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ready           : registered, high once every location has been initialised
//   init_we_c       : init write strobe for the current cycle
//   init_idx_c      : init write index
//   init_data_c     : init write data (index zero-extended/truncated to DATA_W)
module dmem_init_seq
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned IDX_W  = $clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              init_we_c,
    output logic [IDX_W-1:0]  init_idx_c,
    output logic [DATA_W-1:0] init_data_c
);

    state_t           state;
    logic [IDX_W-1:0] cnt;

    // State, counter and ready register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + IDX_W'(1);
                    if (cnt == IDX_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign init_we_c   = (state == ST_INIT);
    assign init_idx_c  = cnt;
    assign init_data_c = DATA_W'(cnt);

endmodule

// File: rtl/dmem_dual_port.sv
// dmem_dual_port: two-port data memory with registered reads (1-cycle latency),
// write-first cross-port forwarding, port 1 winning same-index write conflicts,
// and a hardware init sequence that preloads mem[i] = i after reset.
// Optional macro DMEM_ADDR_CHECK_EN: flags accesses with nonzero address bits above
// the index, suppresses such writes, returns 0 for such reads and pulses errN.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   ready                     : init complete, requests accepted
//   req0/1, we0/1             : request valid, write (1) / read (0)
//   addr0/1, wdata0/1         : word address, write data
//   rdata0/1, rvalid0/1       : registered read data and its one-cycle valid
//   err0/1                    : out-of-range pulse (0 unless DMEM_ADDR_CHECK_EN)
module dmem_dual_port
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              err1
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we_c;
    logic [IDX_W-1:0]  init_idx_c;
    logic [DATA_W-1:0] init_data_c;

    logic              acc0_c, acc1_c;
    logic              oor0_c, oor1_c;
    logic              wr0_c, wr1_c, rd0_c, rd1_c;
    logic [IDX_W-1:0]  idx0_c, idx1_c;
    logic [DATA_W-1:0] rd_val0_c, rd_val1_c;

    dmem_init_seq #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .init_we_c   (init_we_c),
        .init_idx_c  (init_idx_c),
        .init_data_c (init_data_c)
    );

    assign acc0_c = req0 & ready;
    assign acc1_c = req1 & ready;
    assign idx0_c = addr0[IDX_W-1:0];
    assign idx1_c = addr1[IDX_W-1:0];

`ifdef DMEM_ADDR_CHECK_EN
    // Shift rather than slice so IDX_W == ADDR_W needs no special case.
    assign oor0_c = acc0_c & ((addr0 >> IDX_W) != '0);
    assign oor1_c = acc1_c & ((addr1 >> IDX_W) != '0);
`else
    // Upper address bits alias onto the index range.
    logic unused_addr_c;
    assign unused_addr_c = ^{addr0, addr1};
    assign oor0_c = 1'b0;
    assign oor1_c = 1'b0;
`endif

    assign wr0_c = acc0_c &  we0 & ~oor0_c;
    assign wr1_c = acc1_c &  we1 & ~oor1_c;
    assign rd0_c = acc0_c & ~we0;
    assign rd1_c = acc1_c & ~we1;

    // Write-first: a same-cycle write on the other port is forwarded to the read.
    always_comb begin
        rd_val0_c = mem[idx0_c];
        rd_val1_c = mem[idx1_c];
        if (wr1_c && (idx1_c == idx0_c)) rd_val0_c = wdata1;
        if (wr0_c && (idx0_c == idx1_c)) rd_val1_c = wdata0;
        if (oor0_c) rd_val0_c = '0;
        if (oor1_c) rd_val1_c = '0;
    end

    // Array writes; init and port writes never overlap since ports need ready.
    // Port 1 is written last so it wins a same-index conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we_c) mem[init_idx_c] <= init_data_c;
            if (wr0_c)     mem[idx0_c]     <= wdata0;
            if (wr1_c)     mem[idx1_c]     <= wdata1;
        end
    end

    // Read data, valid and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= rd0_c;
            rvalid1 <= rd1_c;
            err0    <= oor0_c;
            err1    <= oor1_c;
            if (rd0_c) rdata0 <= rd_val0_c;
            if (rd1_c) rdata1 <= rd_val1_c;
        end
    end

endmodule

// File: tb/tb_dmem_dual_port.sv
// tb_dmem_dual_port: directed self-checking bench for dmem_dual_port (default geometry).
// Honours DMEM_ADDR_CHECK_EN for the out-of-range expectations.
module tb_dmem_dual_port;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic [15:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, err0, err1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    dmem_dual_port dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .rdata0  (rdata0),
        .rvalid0 (rvalid0),
        .err0    (err0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1),
        .err1    (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;

        // Reset for two cycles.
        step();
        step();
        check("rst_ready",   32'(ready),   32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rdata0",  32'(rdata0),  32'd0);
        check("rst_err0",    32'(err0),    32'd0);

        // Init: ready low for 255 edges, high at edge 256; reads in INIT ignored.
        rst  = 1'b0;
        req0 = 1'b1;
        addr0 = 16'h0003;
        for (int i = 0; i < 255; i++) step();
        check("init_ready_255", 32'(ready),   32'd0);
        check("init_no_rvalid", 32'(rvalid0), 32'd0);
        step();
        check("init_ready_256", 32'(ready),   32'd1);
        check("init_rvalid_256", 32'(rvalid0), 32'd0);
        idle();

        // Initial contents.
        req0 = 1'b1; addr0 = 16'h0005;
        req1 = 1'b1; addr1 = 16'h00FF;
        step();
        check("init_rd5",     32'(rdata0),  32'h0005);
        check("init_rv0",     32'(rvalid0), 32'd1);
        check("init_rdff",    32'(rdata1),  32'h00FF);
        check("init_rv1",     32'(rvalid1), 32'd1);
        idle();

        // Same-index dual write: port 1 wins.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hAAAA;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 16'h5555;
        step();
        check("ww_no_rvalid", 32'(rvalid0), 32'd0);
        idle();
        req0 = 1'b1; addr0 = 16'h0010;
        step();
        check("ww_rd", 32'(rdata0), 32'h5555);
        idle();

        // Forwarding port 0 -> port 1.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1234;
        req1 = 1'b1; addr1 = 16'h0020;
        step();
        check("fwd01_rdata1",  32'(rdata1),  32'h1234);
        check("fwd01_rvalid1", 32'(rvalid1), 32'd1);
        check("fwd01_rvalid0", 32'(rvalid0), 32'd0);
        idle();

        // Forwarding port 1 -> port 0, plus the earlier write landed.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0021; wdata1 = 16'hCAFE;
        req0 = 1'b1; addr0 = 16'h0021;
        step();
        check("fwd10_rdata0", 32'(rdata0), 32'hCAFE);
        idle();
        req0 = 1'b1; addr0 = 16'h0020;
        step();
        check("fwd01_landed", 32'(rdata0), 32'h1234);
        idle();

        // Read-read then hold.
        req0 = 1'b1; addr0 = 16'h0030;
        req1 = 1'b1; addr1 = 16'h0030;
        step();
        check("rr_rdata0", 32'(rdata0), 32'h0030);
        check("rr_rdata1", 32'(rdata1), 32'h0030);
        idle();
        step();
        check("hold_rvalid0_1", 32'(rvalid0), 32'd0);
        step();
        step();
        check("hold_rvalid0_3", 32'(rvalid0), 32'd0);
        check("hold_rvalid1_3", 32'(rvalid1), 32'd0);
        check("hold_rdata0",    32'(rdata0),  32'h0030);
        check("hold_rdata1",    32'(rdata1),  32'h0030);

        // Mid-operation reset drops the in-flight read and re-inits.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = 16'hBEEF;
        step();
        idle();
        req0 = 1'b1; addr0 = 16'h0040;
        rst = 1'b1;
        step();
        check("mid_rvalid0", 32'(rvalid0), 32'd0);
        check("mid_ready",   32'(ready),   32'd0);
        rst = 1'b0;
        // A write attempted during init must be ignored.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0041; wdata0 = 16'hDEAD;
        cyc = 0;
        while (!ready && cyc < 300) begin
            step();
            cyc++;
        end
        check("reinit_len", 32'(cyc), 32'd256);
        idle();
        req0 = 1'b1; addr0 = 16'h0040;
        req1 = 1'b1; addr1 = 16'h0041;
        step();
        check("reinit_rd40", 32'(rdata0), 32'h0040);
        check("reinit_rd41", 32'(rdata1), 32'h0041);
        idle();

        // Out-of-range write and read.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0140; wdata0 = 16'h7777;
        step();
`ifdef DMEM_ADDR_CHECK_EN
        check("oor_wr_err0", 32'(err0), 32'd1);
`else
        check("oor_wr_err0", 32'(err0), 32'd0);
`endif
        idle();
        req0 = 1'b1; addr0 = 16'h0040;
        step();
        check("oor_err0_clear", 32'(err0), 32'd0);
`ifdef DMEM_ADDR_CHECK_EN
        check("oor_mem40", 32'(rdata0), 32'h0040);
`else
        check("oor_mem40", 32'(rdata0), 32'h7777);
`endif
        idle();
        req0 = 1'b1; addr0 = 16'h0140;
        step();
        check("oor_rd_rvalid0", 32'(rvalid0), 32'd1);
`ifdef DMEM_ADDR_CHECK_EN
        check("oor_rd_rdata0", 32'(rdata0), 32'h0000);
        check("oor_rd_err0",   32'(err0),   32'd1);
`else
        check("oor_rd_rdata0", 32'(rdata0), 32'h7777);
        check("oor_rd_err0",   32'(err0),   32'd0);
`endif
        check("oor_err1", 32'(err1), 32'd0);
        idle();
        step();
        check("err0_pulse_end", 32'(err0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
